// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle instruction sequencer.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. It raises the
// memory and write-back strobes and counts cycles and retired instructions.
// If an awaited memory acknowledge does not arrive in time, it parks in TRAP.
//
// Handshake: o_imem_req / o_dmem_req stay high in their state until the
// matching ack is seen. The ack completes the transfer in the same cycle it is
// sampled high. Acks seen outside the requesting state are ignored.
module ctrl_fsm #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_imem_ack,
  input  logic             i_dmem_ack,
  input  logic             i_resume,
  output logic [2:0]       o_state,
  output logic [5:0]       o_format,
  output logic             o_imem_req,
  output logic             o_ir_en,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic             o_pc_wr,
  output logic             o_reg_wr_en,
  output logic             o_halt,
  output logic             o_trap,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The wait count reaches WAIT_LAST on the TIMEOUT-th cycle without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state, state_nxt;
  logic [5:0]       format_q, format_dec;
  logic [7:0]       wait_cnt;
  logic             halt_q, trap_q;
  logic [CNT_W-1:0] cycle_cnt, instret;
  logic             retire;
  logic             imem_req, ir_en, dmem_req, dmem_we, pc_wr, reg_wr_en;
  logic             is_store, is_mem;

  assign is_store = (i_opcode == OP_STORE);
  assign is_mem   = (i_opcode == OP_LOAD) || is_store;

  // Opcode to one-hot format. Unsupported and system opcodes decode to zero.
  always_comb begin
    format_dec = 6'b000000;
    case (i_opcode)
      OP_R:                      format_dec = 6'b000001;
      OP_IMM, OP_LOAD, OP_JALR:  format_dec = 6'b000010;
      OP_STORE:                  format_dec = 6'b000100;
      OP_BRANCH:                 format_dec = 6'b001000;
      OP_LUI, OP_AUIPC:          format_dec = 6'b010000;
      OP_JAL:                    format_dec = 6'b100000;
      default:                   format_dec = 6'b000000;
    endcase
  end

  // Next-state, strobe and retirement logic.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_en     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_wr     = 1'b0;
    reg_wr_en = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (i_imem_ack) begin
          ir_en     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        if (i_opcode == OP_SYSTEM)  state_nxt = S_HALT;
        else if (format_dec == '0)  state_nxt = S_TRAP;
        else                        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (is_mem) begin
          state_nxt = S_MEM;
        end else if (i_opcode == OP_BRANCH) begin
          pc_wr     = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (i_dmem_ack) begin
          if (is_store) begin
            pc_wr     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        reg_wr_en = 1'b1;
        pc_wr     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (i_resume) begin
          pc_wr     = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_TRAP;
    endcase
  end

  // State register plus sticky halt/trap flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state  <= S_FETCH;
      halt_q <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      halt_q <= (state_nxt == S_HALT);
      trap_q <= (state_nxt == S_TRAP);
    end
  end

  // Format is captured once per instruction, in DECODE.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                format_q <= '0;
    else if (state == S_DECODE) format_q <= format_dec;
  end

  // Ack wait counter: restarts on every state change, counts cycles without an ack.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt <= '0;
    end else if (state_nxt != state) begin
      wait_cnt <= '0;
    end else if ((state == S_FETCH && !i_imem_ack) ||
                 (state == S_MEM && !i_dmem_ack)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Performance counters; both wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cycle_cnt <= '0;
      instret   <= '0;
    end else begin
      if (state != S_HALT && state != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
      if (retire)                             instret   <= instret + 1'b1;
    end
  end

  // Strobes are forced low while reset is held so no request survives reset.
  assign o_imem_req  = i_rst & imem_req;
  assign o_ir_en     = i_rst & ir_en;
  assign o_dmem_req  = i_rst & dmem_req;
  assign o_dmem_we   = i_rst & dmem_we;
  assign o_pc_wr     = i_rst & pc_wr;
  assign o_reg_wr_en = i_rst & reg_wr_en;

  assign o_state     = state;
  assign o_format    = format_q;
  assign o_halt      = halt_q;
  assign o_trap      = trap_q;
  assign o_cycle_cnt = cycle_cnt;
  assign o_instret   = instret;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm (TIMEOUT=4, CNT_W=4) with hand-computed expectations.
module tb_ctrl_fsm;

  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [6:0]       i_opcode;
  logic             i_imem_ack, i_dmem_ack, i_resume;
  logic [2:0]       o_state;
  logic [5:0]       o_format;
  logic             o_imem_req, o_ir_en, o_dmem_req, o_dmem_we;
  logic             o_pc_wr, o_reg_wr_en, o_halt, o_trap;
  logic [CNT_W-1:0] o_cycle_cnt, o_instret;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Clock and reset block
  always #5 i_clk = ~i_clk;

  ctrl_fsm #(.CNT_W(CNT_W), .TIMEOUT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode),
    .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack), .i_resume(i_resume),
    .o_state(o_state), .o_format(o_format),
    .o_imem_req(o_imem_req), .o_ir_en(o_ir_en),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_pc_wr(o_pc_wr), .o_reg_wr_en(o_reg_wr_en),
    .o_halt(o_halt), .o_trap(o_trap),
    .o_cycle_cnt(o_cycle_cnt), .o_instret(o_instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_state"},   32'(o_state), 32'd0);
    chk({tag, "_format"},  32'(o_format), 32'd0);
    chk({tag, "_strobes"}, 32'({o_imem_req, o_ir_en, o_dmem_req, o_dmem_we, o_pc_wr, o_reg_wr_en}), 32'd0);
    chk({tag, "_flags"},   32'({o_halt, o_trap}), 32'd0);
    chk({tag, "_cyc"},     32'(o_cycle_cnt), 32'd0);
    chk({tag, "_instret"}, 32'(o_instret), 32'd0);
  endtask

  // Hold reset across one edge, check the reset state, then release mid-cycle.
  task automatic do_reset(input string tag);
    i_rst = 1'b0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_resume = 1'b0;
    cyc();
    chk_all_low(tag);
    i_rst = 1'b1;
    settle();
    chk({tag, "_rel_state"}, 32'(o_state), 32'd0);
    chk({tag, "_rel_ireq"},  32'(o_imem_req), 32'd1);
  endtask

  initial begin
    i_rst = 1'b0; i_opcode = 7'd0; i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_resume = 1'b0;

    // R-type, imem ack on second FETCH cycle
    do_reset("rst0");
    i_opcode = 7'b0110011;
    chk("r_f0_irEn", 32'(o_ir_en), 32'd0);
    cyc();
    i_imem_ack = 1'b1; settle();
    chk("r_f1_state", 32'(o_state), 32'd0);
    chk("r_f1_irEn",  32'(o_ir_en), 32'd1);
    cyc(); i_imem_ack = 1'b0;
    chk("r_decode", 32'(o_state), 32'd1);
    chk("r_dec_wr", 32'(o_reg_wr_en), 32'd0);
    cyc();
    chk("r_exec",   32'(o_state), 32'd2);
    chk("r_format", 32'(o_format), 32'b000001);
    cyc();
    chk("r_wb",     32'(o_state), 32'd4);
    chk("r_wb_wr",  32'(o_reg_wr_en), 32'd1);
    chk("r_wb_pc",  32'(o_pc_wr), 32'd1);
    cyc();
    chk("r_fetch2",  32'(o_state), 32'd0);
    chk("r_wr_off",  32'(o_reg_wr_en), 32'd0);
    chk("r_instret", 32'(o_instret), 32'd1);
    chk("r_cyc",     32'(o_cycle_cnt), 32'd5);

    // Continue into a load, then reset asynchronously while in MEM
    i_opcode = 7'b0000011; i_imem_ack = 1'b1;
    cyc(); i_imem_ack = 1'b0;
    cyc();
    cyc();
    chk("mr_mem",  32'(o_state), 32'd3);
    chk("mr_dreq", 32'(o_dmem_req), 32'd1);
    i_rst = 1'b0; settle();
    chk_all_low("mr_async");
    i_rst = 1'b1; settle();
    chk("mr_rel_ireq", 32'(o_imem_req), 32'd1);
    cyc();
    chk("mr_restart_state", 32'(o_state), 32'd0);
    chk("mr_restart_cyc",   32'(o_cycle_cnt), 32'd1);

    // Load, dmem ack on third MEM cycle
    do_reset("rst_ld");
    i_opcode = 7'b0000011; i_imem_ack = 1'b1;
    cyc(); i_imem_ack = 1'b0;
    cyc();
    chk("ld_format", 32'(o_format), 32'b000010);
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i_dmem_ack = 1'b1;
      settle();
      chk($sformatf("ld_mem%0d_state", i), 32'(o_state), 32'd3);
      chk($sformatf("ld_mem%0d_req", i), 32'({o_dmem_req, o_dmem_we}), 32'b10);
      chk($sformatf("ld_mem%0d_pc", i), 32'(o_pc_wr), 32'd0);
      cyc();
    end
    i_dmem_ack = 1'b0;
    chk("ld_wb",    32'(o_state), 32'd4);
    chk("ld_wb_wr", 32'(o_reg_wr_en), 32'd1);
    cyc();
    chk("ld_instret", 32'(o_instret), 32'd1);

    // Store, same timing, then illegal opcode 0000000 traps
    do_reset("rst_st");
    i_opcode = 7'b0100011; i_imem_ack = 1'b1;
    cyc(); i_imem_ack = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) i_dmem_ack = 1'b1;
      settle();
      chk($sformatf("st_mem%0d_req", i), 32'({o_dmem_req, o_dmem_we}), 32'b11);
      chk($sformatf("st_mem%0d_pc", i), 32'(o_pc_wr), (i == 2) ? 32'd1 : 32'd0);
      chk($sformatf("st_mem%0d_wr", i), 32'(o_reg_wr_en), 32'd0);
      cyc();
    end
    i_dmem_ack = 1'b0;
    chk("st_fetch",   32'(o_state), 32'd0);
    chk("st_instret", 32'(o_instret), 32'd1);
    chk("st_cyc",     32'(o_cycle_cnt), 32'd6);
    i_opcode = 7'b0000000; i_imem_ack = 1'b1;
    cyc(); i_imem_ack = 1'b0;
    chk("ill_dec_format", 32'(o_format), 32'b000100);
    cyc();
    chk("ill_trap",   32'(o_state), 32'd6);
    chk("ill_flag",   32'(o_trap), 32'd1);
    chk("ill_format", 32'(o_format), 32'd0);

    // Fetch timeout: no ack for 4 cycles traps; trap ignores inputs
    do_reset("rst_to");
    cyc(); cyc(); cyc();
    chk("to_f3_state", 32'(o_state), 32'd0);
    cyc();
    chk("to_trap",  32'(o_state), 32'd6);
    chk("to_flag",  32'(o_trap), 32'd1);
    chk("to_cyc",   32'(o_cycle_cnt), 32'd4);
    i_imem_ack = 1'b1; i_dmem_ack = 1'b1; i_resume = 1'b1;
    settle();
    chk("to_strobes", 32'({o_imem_req, o_ir_en, o_dmem_req, o_pc_wr}), 32'd0);
    cyc(); cyc(); cyc();
    chk("to_stay",   32'(o_state), 32'd6);
    chk("to_frozen", 32'(o_cycle_cnt), 32'd4);
    i_imem_ack = 1'b0; i_dmem_ack = 1'b0; i_resume = 1'b0;

    // Ack on the 4th wait cycle wins over the timeout
    do_reset("rst_ta");
    i_opcode = 7'b0110011;
    cyc(); cyc(); cyc();
    i_imem_ack = 1'b1; settle();
    chk("ta_irEn", 32'(o_ir_en), 32'd1);
    cyc(); i_imem_ack = 1'b0;
    chk("ta_decode", 32'(o_state), 32'd1);
    chk("ta_notrap", 32'(o_trap), 32'd0);

    // HALT: counters frozen, single-cycle resume
    do_reset("rst_h");
    i_opcode = 7'b1110011; i_imem_ack = 1'b1;
    cyc(); i_imem_ack = 1'b0;
    cyc();
    chk("h_state", 32'(o_state), 32'd5);
    chk("h_flag",  32'(o_halt), 32'd1);
    chk("h_cyc",   32'(o_cycle_cnt), 32'd2);
    for (int i = 0; i < 10; i++) cyc();
    chk("h_stay",   32'(o_state), 32'd5);
    chk("h_frozen", 32'(o_cycle_cnt), 32'd2);
    chk("h_pc_idle", 32'(o_pc_wr), 32'd0);
    i_resume = 1'b1; settle();
    chk("h_res_pc", 32'(o_pc_wr), 32'd1);
    cyc(); i_resume = 1'b0;
    chk("h_fetch",   32'(o_state), 32'd0);
    chk("h_clear",   32'(o_halt), 32'd0);
    chk("h_instret", 32'(o_instret), 32'd0);
    chk("h_cyc_res", 32'(o_cycle_cnt), 32'd2);
    i_dmem_ack = 1'b1; settle();
    chk("h_stray_dack", 32'(o_dmem_req), 32'd0);
    cyc(); i_dmem_ack = 1'b0;
    chk("h_stray_state", 32'(o_state), 32'd0);
    chk("h_cyc_run",     32'(o_cycle_cnt), 32'd3);

    // 16 back-to-back branches wrap the 4-bit retired counter
    do_reset("rst_br");
    i_opcode = 7'b1100011; i_imem_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("br%0d_instret", i), 32'(o_instret), 32'(i));
      cyc(); cyc();
      chk($sformatf("br%0d_pc", i), 32'({o_state, o_pc_wr}), {28'd0, 3'd2, 1'b1});
      cyc();
    end
    i_imem_ack = 1'b0;
    chk("br_wrap",  32'(o_instret), 32'd0);
    chk("br_state", 32'(o_state), 32'd0);
    chk("br_cyc",   32'(o_cycle_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
